fifo_sched_ctrl: RTL and testbench
==================================

FIFO_SCHED_CTRL -- requirements
Module: fifo_sched_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of all sample data ports.
REQ-002 Parameter BURST_LEN, default 4, range 1..255, SHALL set the number of FIFO reads per burst.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1 each  SHALL mean producer 0 / producer 1 has a sample to write.
REQ-006 req0_data / req1_data  input  DATA_W each  SHALL carry the producer samples.
REQ-007 req0_ready / req1_ready  output  1 each  SHALL mean the sample is accepted this cycle.
REQ-008 fifo_wr_en  output  1, fifo_wr_data  output  DATA_W  SHALL form the FIFO write port.
REQ-009 fifo_full, fifo_empty  input  1 each  SHALL carry the FIFO status flags.
REQ-010 fifo_rd_en  output  1, fifo_rd_data  input  DATA_W  SHALL form the FIFO read port; head word is valid on fifo_rd_data whenever fifo_empty=0.
REQ-011 burst_req  input  1  SHALL request one burst of BURST_LEN reads.
REQ-012 out_valid  output  1, out_data  output  DATA_W  SHALL present each read sample.
REQ-013 burst_done  output  1  SHALL pulse for one cycle when a burst completes.
REQ-014 stall_cnt  output  16  SHALL report the write-stall statistic (see Configuration).

Function
REQ-015 Write arbiter SHALL be round-robin over two requesters, with a 1-bit last_grant register.
REQ-016 Only one reqN_valid=1: that requester SHALL be granted; both valid: the requester not equal to last_grant SHALL be granted.
REQ-017 reqN_ready SHALL be combinational = granted(N) AND NOT fifo_full; it SHALL never be 1 for both requesters.
REQ-018 fifo_wr_en SHALL equal OR of (reqN_valid AND reqN_ready); fifo_wr_data SHALL be the granted requester's data (zero-latency path).
REQ-019 last_grant SHALL update to the accepted requester only on a cycle where fifo_wr_en=1; it SHALL hold when fifo_full=1.
REQ-020 Read sequencer SHALL be an FSM with states IDLE, BURST, DONE.
REQ-021 IDLE: burst_req=1 SHALL move to BURST and clear the 8-bit read counter rd_cnt; burst_req SHALL be ignored in BURST and DONE.
REQ-022 BURST: fifo_rd_en SHALL be combinational = NOT fifo_empty; each issued read SHALL increment rd_cnt.
REQ-023 BURST: an issued read with rd_cnt=BURST_LEN-1 SHALL move to DONE; fifo_empty=1 SHALL stall the burst without timeout.
REQ-024 DONE SHALL assert burst_done for exactly one cycle, then return to IDLE; fifo_rd_en SHALL be 0 in IDLE and DONE.
REQ-025 On each fifo_rd_en=1 cycle, out_data SHALL register fifo_rd_data and out_valid SHALL be 1 the next cycle (latency 1); otherwise out_valid=0 and out_data holds.
REQ-026 Write and read paths SHALL be independent; a write and a read in the same cycle are both performed.

Reset
REQ-027 rst_n=0 SHALL immediately force FSM=IDLE, rd_cnt=0, last_grant=1 (producer 0 wins the first tie), out_valid=0, out_data=0, burst_done=0, stall_cnt=0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no burst_done pulse; FIFO contents are not this block's concern.

Configuration
REQ-029 Macro FIFO_SCHED_CTRL_STATS_EN defined: stall_cnt SHALL increment by 1 on each cycle with (req0_valid OR req1_valid) AND fifo_full, saturating at 16'hFFFF.
REQ-030 Macro undefined: the counter SHALL not be built and stall_cnt SHALL be tied to 0.

Verification
REQ-031 Both producers valid continuously, fifo_full=0, data 0xA000+n / 0xB000+n -> writes alternate P0,P1,P0,P1 starting with P0.
REQ-032 P1 alone valid for 3 cycles, then both valid -> 3 P1 writes, then P0 granted first.
REQ-033 Both valid with fifo_full=1 for 5 cycles -> fifo_wr_en=0, both readies 0, stall_cnt=5 with macro / 0 without; after full clears, P0 granted first.
REQ-034 BURST_LEN=4, FIFO holding 0x0011..0x0044, burst_req pulse -> 4 rd_en cycles, out_valid 4 cycles each one cycle later with 0x0011..0x0044, burst_done one cycle after last read.
REQ-035 Burst with fifo_empty=1 after 2 reads, cleared 3 cycles later -> rd_en gaps for 3 cycles, burst completes with exactly 4 reads.
REQ-036 rst_n pulsed low after 2 of 4 reads -> outputs at reset values asynchronously, FSM IDLE, no burst_done pulse.

Source files
------------

// File: rtl/fifo_sched_ctrl.sv
// rtl/fifo_sched_ctrl.sv - two-producer round-robin FIFO writer with a burst read sequencer.
// Optional write-stall counter is built when FIFO_SCHED_CTRL_STATS_EN is defined.
module fifo_sched_ctrl #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              burst_req,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              burst_done,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    state_t            state_q, state_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              grant0, grant1;

    // Tie goes to whichever producer was not accepted last.
    always_comb begin
        grant0       = req0_valid && (!req1_valid || last_grant_q);
        grant1       = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready   = grant0 && !fifo_full;
        req1_ready   = grant1 && !fifo_full;
        fifo_wr_en   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        fifo_wr_data = grant1 ? req1_data : req0_data;
        last_grant_d = last_grant_q;
        if (fifo_wr_en) begin
            last_grant_d = req1_ready;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        fifo_rd_en = 1'b0;
        burst_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (burst_req) begin
                    state_d  = S_BURST;
                    rd_cnt_d = 8'd0;
                end
            end
            S_BURST: begin
                fifo_rd_en = !fifo_empty;
                if (fifo_rd_en) begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                burst_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        out_valid_d = fifo_rd_en;
        out_data_d  = fifo_rd_en ? fifo_rd_data : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rd_cnt_q     <= 8'd0;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef FIFO_SCHED_CTRL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((req0_valid || req1_valid) && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_sched_ctrl.sv
// tb/tb_fifo_sched_ctrl.sv - self-checking bench for fifo_sched_ctrl against a queue-based reference model.
module tb_fifo_sched_ctrl;

    localparam int DW = 16;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_full = 1'b0, fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          burst_req = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          burst_done;
    logic [15:0]   stall_cnt;

    fifo_sched_ctrl #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .burst_req(burst_req), .out_valid(out_valid), .out_data(out_data),
        .burst_done(burst_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who was served last, how many burst reads remain, and the FIFO contents.
    logic          m_last;
    int            m_mode;
    int            m_left;
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic [15:0]   m_stall;
    logic [DW-1:0] rd_q[$];
    logic          wr_src[$];
    logic [DW-1:0] out_log[$];
    int            n_rd, n_done;

`ifdef FIFO_SCHED_CTRL_STATS_EN
    localparam logic [15:0] EXP_STALL5 = 16'd5;
`else
    localparam logic [15:0] EXP_STALL5 = 16'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = 1'b1;
        m_mode  = 0;
        m_left  = 0;
        m_ov    = 1'b0;
        m_od    = '0;
        m_stall = 16'd0;
        rd_q.delete();
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
    task automatic do_reset(input logic idle_inputs);
        if (idle_inputs) begin
            req0_valid = 1'b0; req1_valid = 1'b0; burst_req = 1'b0; fifo_full = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_burst_done", 32'(burst_done), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic cycle(input logic v0, input logic [DW-1:0] d0, input logic v1,
                         input logic [DW-1:0] d1, input logic full, input logic ef,
                         input logic breq);
        int   g;
        logic e0, e1, ewr, erd;
        req0_valid   = v0; req0_data = d0;
        req1_valid   = v1; req1_data = d1;
        fifo_full    = full;
        burst_req    = breq;
        fifo_empty   = ef || (rd_q.size() == 0);
        fifo_rd_data = (rd_q.size() != 0) ? rd_q[0] : '0;
        #1;
        g   = (v0 && v1) ? (m_last ? 0 : 1) : (v1 ? 1 : 0);
        e0  = v0 && (g == 0) && !full;
        e1  = v1 && (g == 1) && !full;
        ewr = e0 || e1;
        erd = (m_mode == 1) && !fifo_empty;
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("wr_en", 32'(fifo_wr_en), 32'(ewr));
        if (ewr) chk("wr_data", 32'(fifo_wr_data), 32'(g == 1 ? d1 : d0));
        chk("rd_en", 32'(fifo_rd_en), 32'(erd));
        chk("burst_done", 32'(burst_done), 32'(m_mode == 2));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (fifo_wr_en) wr_src.push_back(req1_ready);
        if (out_valid) out_log.push_back(out_data);
        if (fifo_rd_en) n_rd++;
        if (burst_done) n_done++;
        if (ewr) m_last = (g == 1);
`ifdef FIFO_SCHED_CTRL_STATS_EN
        if ((v0 || v1) && full && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
`endif
        m_ov = erd;
        if (erd) begin
            m_od = rd_q.pop_front();
            m_left--;
        end
        case (m_mode)
            0: if (breq) begin m_mode = 1; m_left = BL; end
            1: if (erd && (m_left == 0)) m_mode = 2;
            default: m_mode = 0;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_src.delete(); out_log.delete(); n_rd = 0; n_done = 0;
    endtask

    initial begin
        model_reset();
        clear_logs();
        #2 rst_n = 1'b0;
        #1;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_data", 32'(out_data), 32'd0);
        chk("init_burst_done", 32'(burst_done), 32'd0);
        chk("init_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous contention alternates starting with producer 0.
        clear_logs();
        for (int n = 0; n < 8; n++) cycle(1, 16'hA000 + 16'(n), 1, 16'hB000 + 16'(n), 0, 0, 0);
        chk("alt_count", 32'(wr_src.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_src.size(); i++) chk("alt_src", 32'(wr_src[i]), 32'(i % 2));

        // Producer 1 alone, then contention hands the next grant to producer 0.
        do_reset(1);
        clear_logs();
        for (int n = 0; n < 3; n++) cycle(0, 16'h0, 1, 16'hB100 + 16'(n), 0, 0, 0);
        cycle(1, 16'hA100, 1, 16'hB103, 0, 0, 0);
        chk("p1_then_both_count", 32'(wr_src.size()), 32'd4);
        if (wr_src.size() == 4) begin
            chk("p1_then_both_src2", 32'(wr_src[2]), 32'd1);
            chk("p1_then_both_src3", 32'(wr_src[3]), 32'd0);
        end

        // Full FIFO blocks both producers and counts stall cycles.
        do_reset(1);
        clear_logs();
        for (int n = 0; n < 5; n++) cycle(1, 16'hA200, 1, 16'hB200, 1, 0, 0);
        chk("full_no_writes", 32'(wr_src.size()), 32'd0);
        chk("full_stall_cnt", 32'(stall_cnt), 32'(EXP_STALL5));
        cycle(1, 16'hA201, 1, 16'hB201, 0, 0, 0);
        chk("full_then_p0", (wr_src.size() == 1) ? 32'(wr_src[0]) : 32'hDEAD, 32'd0);

        // Clean burst of four reads.
        do_reset(1);
        clear_logs();
        rd_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 6; n++) cycle(0, 0, 0, 0, 0, 0, 0);
        chk("burst_reads", 32'(n_rd), 32'd4);
        chk("burst_done_cnt", 32'(n_done), 32'd1);
        chk("burst_out_cnt", 32'(out_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            chk("burst_out_data", 32'(out_log[i]), 32'(16'h0011 * 16'(i + 1)));

        // Empty flag stalls the burst mid-way without losing a read.
        clear_logs();
        rd_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 2; n++) cycle(0, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 3; n++) cycle(0, 0, 0, 0, 0, 1, 1);
        chk("stall_gap_reads", 32'(n_rd), 32'd2);
        for (int n = 0; n < 5; n++) cycle(0, 0, 0, 0, 0, 0, 0);
        chk("stall_total_reads", 32'(n_rd), 32'd4);
        chk("stall_done_cnt", 32'(n_done), 32'd1);

        // Reset in the middle of a burst abandons it silently.
        clear_logs();
        rd_q = '{16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 2; n++) cycle(0, 0, 0, 0, 0, 0, 0);
        chk("midrst_out_valid_before", 32'(out_valid), 32'd1);
        do_reset(0);
        for (int n = 0; n < 6; n++) cycle(0, 0, 0, 0, 0, 0, 0);
        chk("midrst_reads", 32'(n_rd), 32'd2);
        chk("midrst_no_done", 32'(n_done), 32'd0);

        // Random traffic on both paths.
        for (int n = 0; n < 300; n++) begin
            if (rd_q.size() < 3) rd_q.push_back(16'($urandom));
            cycle(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
                  ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
